// File: rtl/agusec_fault_pipe_pkg.sv
// agusec_fault_pipe_pkg
// Shared definitions for the AGU security fault pipe.
// Holds the fault-record field widths and the packed fault-record struct
// that the output stage and the fault FIFO exchange. The pointer-field
// macro below falls back to the struct-header layout when the shared header
// has not already provided it.

`ifndef PTR_EXP
`define PTR_EXP 63:59
`endif

package agusec_fault_pipe_pkg;

  localparam int FREC_II_W   = 10;
  localparam int FREC_EXP_W  = 5;
  localparam int FREC_ADDR_W = 40;

  // The recorded address is the checked pointer with the low nibble dropped.
  localparam int ADDR_LSB = 4;
  localparam int ADDR_MSB = ADDR_LSB + FREC_ADDR_W - 1;

  typedef struct packed {
    logic [FREC_II_W-1:0]   ii;
    logic [FREC_EXP_W-1:0]  exp;
    logic [FREC_ADDR_W-1:0] addr;
  } agusec_frec_t;

endpackage

// File: rtl/agusec_fault_fifo.sv
// agusec_fault_fifo
// Small fault-record FIFO drained by the exception unit.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push, push_rec  write a fault record (dropped and counted when full)
//   pop           consume the head entry (ignored while empty)
//   clr           empty the FIFO and clear the overflow bookkeeping
//   valid, head   FIFO non-empty and combinational head entry
//   ovf, drops    sticky overflow flag and saturating drop counter

module agusec_fault_fifo
  import agusec_fault_pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  agusec_frec_t       push_rec,
  input  logic               pop,
  input  logic               clr,
  output logic               valid,
  output agusec_frec_t       head,
  output logic               ovf,
  output logic [CNT_W-1:0]   drops
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  agusec_frec_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic empty;
  logic full;
  logic do_pop;
  logic do_push;
  logic do_drop;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // indices with differing wrap bits mean full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A same-cycle pop frees the slot a full-FIFO push needs.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign do_drop = push & full & ~do_pop;

  assign valid = ~empty;
  assign head  = mem[rd_ptr[AW-1:0]];

  // Clear wins over any same-cycle push or pop; the discarded push is not
  // counted as a drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      drops  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      drops  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_rec;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_drop) begin
        ovf <= 1'b1;
        if (~&drops) begin
          drops <= drops + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/agusec_fault_pipe.sv
// agusec_fault_pipe
// Registered stage after the AGU security range check. Presents a
// one-cycle-delayed pass/fault verdict to the load/store queue and records
// every faulting access in a fault FIFO for the exception unit.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   stall, flush             hold the output stage / kill the in-flight op
//   in_en, in_ptr, in_ok, in_ii   AGU check result (in_ok=1 means pass)
//   out_en, out_fault, out_ii     registered verdict
//   fq_valid, fq_ii, fq_exp, fq_addr   fault FIFO head
//   fq_pop, fq_clr           drain / empty the fault FIFO
//   fq_ovf, fq_drops         sticky overflow and saturating drop count

module agusec_fault_pipe
  import agusec_fault_pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int II_W  = FREC_II_W,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   in_en,
  input  logic [63:0]            in_ptr,
  input  logic                   in_ok,
  input  logic [II_W-1:0]        in_ii,
  output logic                   out_en,
  output logic                   out_fault,
  output logic [II_W-1:0]        out_ii,
  output logic                   fq_valid,
  output logic [II_W-1:0]        fq_ii,
  output logic [FREC_EXP_W-1:0]  fq_exp,
  output logic [FREC_ADDR_W-1:0] fq_addr,
  input  logic                   fq_pop,
  input  logic                   fq_clr,
  output logic                   fq_ovf,
  output logic [CNT_W-1:0]       fq_drops
);

  logic         acc;
  logic         push;
  agusec_frec_t push_rec;
  agusec_frec_t head;

  assign acc  = in_en & ~stall & ~flush;
  // A flush or stall in the same cycle suppresses the record through acc.
  assign push = acc & ~in_ok;

  assign push_rec.ii   = in_ii;
  assign push_rec.exp  = in_ptr[`PTR_EXP];
  assign push_rec.addr = in_ptr[ADDR_MSB:ADDR_LSB];

  // Flush beats stall; a stall without flush freezes the whole output stage,
  // and an idle cycle clears the valid/fault pair but keeps the last index.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_en    <= 1'b0;
      out_fault <= 1'b0;
      out_ii    <= '0;
    end else if (flush) begin
      out_en    <= 1'b0;
      out_fault <= 1'b0;
    end else if (!stall) begin
      if (in_en) begin
        out_en    <= 1'b1;
        out_fault <= ~in_ok;
        out_ii    <= in_ii;
      end else begin
        out_en    <= 1'b0;
        out_fault <= 1'b0;
      end
    end
  end

  agusec_fault_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_rec (push_rec),
    .pop      (fq_pop),
    .clr      (fq_clr),
    .valid    (fq_valid),
    .head     (head),
    .ovf      (fq_ovf),
    .drops    (fq_drops)
  );

  assign fq_ii   = head.ii;
  assign fq_exp  = head.exp;
  assign fq_addr = head.addr;

endmodule

// File: tb/tb_agusec_fault_pipe.sv
// tb_agusec_fault_pipe
// Scenario-driven and randomized bench for agusec_fault_pipe. A behavioural
// model (verdict registers plus a queue of fault records) tracks the
// expected outputs cycle by cycle.

`ifndef PTR_EXP
`define PTR_EXP 63:59
`endif

module tb_agusec_fault_pipe;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [9:0]  ii;
    logic [4:0]  exp;
    logic [39:0] addr;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_en, in_ok, fq_pop, fq_clr;
  logic [63:0] in_ptr;
  logic [9:0]  in_ii;
  logic        out_en, out_fault, fq_valid, fq_ovf;
  logic [9:0]  out_ii, fq_ii;
  logic [4:0]  fq_exp;
  logic [39:0] fq_addr;
  logic [7:0]  fq_drops;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic       m_out_en, m_out_fault;
  logic [9:0] m_out_ii;
  rec_t       mq[$];
  logic       m_ovf;
  int         m_drops;

  agusec_fault_pipe #(.DEPTH(DEPTH), .II_W(10), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_en(in_en),
    .in_ptr(in_ptr), .in_ok(in_ok), .in_ii(in_ii), .out_en(out_en),
    .out_fault(out_fault), .out_ii(out_ii), .fq_valid(fq_valid),
    .fq_ii(fq_ii), .fq_exp(fq_exp), .fq_addr(fq_addr), .fq_pop(fq_pop),
    .fq_clr(fq_clr), .fq_ovf(fq_ovf), .fq_drops(fq_drops)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit   acc;
    bit   popped;
    rec_t r;
    if (rst) begin
      m_out_en = 0; m_out_fault = 0; m_out_ii = '0;
      mq.delete(); m_ovf = 0; m_drops = 0;
      return;
    end
    acc = in_en && !stall && !flush;
    if (flush) begin
      m_out_en = 0; m_out_fault = 0;
    end else if (!stall) begin
      if (acc) begin
        m_out_en = 1; m_out_fault = !in_ok; m_out_ii = in_ii;
      end else begin
        m_out_en = 0; m_out_fault = 0;
      end
    end
    if (fq_clr) begin
      mq.delete(); m_ovf = 0; m_drops = 0;
    end else begin
      popped = 0;
      if (fq_pop && mq.size() > 0) begin
        void'(mq.pop_front());
        popped = 1;
      end
      if (acc && !in_ok) begin
        if (mq.size() < DEPTH) begin
          r.ii = in_ii; r.exp = in_ptr[`PTR_EXP]; r.addr = in_ptr[43:4];
          mq.push_back(r);
        end else begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst = 0; stall = 0; flush = 0; in_en = 0; in_ok = 1;
    in_ptr = '0; in_ii = '0; fq_pop = 0; fq_clr = 0;
  endtask

  task automatic set_fault(input logic [9:0] ii);
    set_idle();
    in_en = 1; in_ok = 0; in_ii = ii; in_ptr = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    cycle();
    cycle();
    set_idle();
    checks++; if (out_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_en: got %0h expected 0", out_en); end
    checks++; if (out_fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_fault: got %0h expected 0", out_fault); end
    checks++; if (out_ii !== 10'h0) begin errors++; $display("[TB] FAIL reset_out_ii: got %0h expected 0", out_ii); end
    checks++; if (fq_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_fq_valid: got %0h expected 0", fq_valid); end
    checks++; if (fq_ovf !== 1'b0 || fq_drops !== 8'h0) begin errors++; $display("[TB] FAIL reset_ovf_drops: got %0h/%0h expected 0/0", fq_ovf, fq_drops); end
  endtask

  task automatic test_pass();
    set_idle();
    in_en = 1; in_ok = 1; in_ii = 10'h05A; in_ptr = {$urandom, $urandom};
    cycle();
    set_idle();
    checks++; if (out_en !== 1'b1) begin errors++; $display("[TB] FAIL pass_out_en: got %0h expected 1", out_en); end
    checks++; if (out_fault !== 1'b0) begin errors++; $display("[TB] FAIL pass_out_fault: got %0h expected 0", out_fault); end
    checks++; if (out_ii !== 10'h05A) begin errors++; $display("[TB] FAIL pass_out_ii: got %0h expected 5a", out_ii); end
    checks++; if (fq_valid !== 1'b0) begin errors++; $display("[TB] FAIL pass_fq_valid: got %0h expected 0", fq_valid); end
    cycle();
    checks++; if (out_en !== 1'b0 || out_ii !== 10'h05A) begin errors++; $display("[TB] FAIL pass_one_cycle: got en=%0h ii=%0h expected en=0 ii=5a", out_en, out_ii); end
  endtask

  task automatic test_fault_record();
    set_fault(10'h101);
    in_ptr = '0;
    in_ptr[`PTR_EXP] = 5'h0C;
    in_ptr[43:4] = 40'h12345678AB;
    cycle();
    set_idle();
    checks++; if (out_en !== 1'b1 || out_fault !== 1'b1) begin errors++; $display("[TB] FAIL fault_out: got en=%0h fault=%0h expected 1/1", out_en, out_fault); end
    checks++; if (fq_valid !== 1'b1) begin errors++; $display("[TB] FAIL fault_fq_valid: got %0h expected 1", fq_valid); end
    checks++; if (fq_ii !== 10'h101) begin errors++; $display("[TB] FAIL fault_fq_ii: got %0h expected 101", fq_ii); end
    checks++; if (fq_exp !== 5'h0C) begin errors++; $display("[TB] FAIL fault_fq_exp: got %0h expected c", fq_exp); end
    checks++; if (fq_addr !== 40'h12345678AB) begin errors++; $display("[TB] FAIL fault_fq_addr: got %0h expected 12345678ab", fq_addr); end
    fq_pop = 1;
    cycle();
    set_idle();
    checks++; if (fq_valid !== 1'b0) begin errors++; $display("[TB] FAIL fault_pop_empty: got %0h expected 0", fq_valid); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      set_fault(10'h200 + 10'(i));
      cycle();
    end
    set_idle();
    checks++; if (fq_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %0h expected 1", fq_ovf); end
    checks++; if (fq_drops !== 8'd2) begin errors++; $display("[TB] FAIL ovf_drops: got %0d expected 2", fq_drops); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (fq_valid !== 1'b1 || fq_ii !== 10'h200 + 10'(i)) begin errors++; $display("[TB] FAIL ovf_order_%0d: got v=%0h ii=%0h expected v=1 ii=%0h", i, fq_valid, fq_ii, 10'h200 + 10'(i)); end
      checks++; if (mq.size() == 0 || fq_addr !== mq[0].addr || fq_exp !== mq[0].exp) begin errors++; $display("[TB] FAIL ovf_fields_%0d: got exp=%0h addr=%0h", i, fq_exp, fq_addr); end
      fq_pop = 1;
      cycle();
      set_idle();
    end
    checks++; if (fq_valid !== 1'b0 || fq_drops !== 8'd2 || fq_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_drained: got v=%0h drops=%0d ovf=%0h expected 0/2/1", fq_valid, fq_drops, fq_ovf); end
    fq_clr = 1;
    cycle();
    set_idle();
    checks++; if (fq_valid !== 1'b0 || fq_drops !== 8'd0 || fq_ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clr: got v=%0h drops=%0d ovf=%0h expected 0/0/0", fq_valid, fq_drops, fq_ovf); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      set_fault(10'h300 + 10'(i));
      cycle();
    end
    set_fault(10'h3FF);
    fq_pop = 1;
    cycle();
    set_idle();
    checks++; if (fq_drops !== 8'd0 || fq_ovf !== 1'b0) begin errors++; $display("[TB] FAIL fpp_no_drop: got drops=%0d ovf=%0h expected 0/0", fq_drops, fq_ovf); end
    for (int i = 0; i < 4; i++) begin
      logic [9:0] exp_ii;
      exp_ii = (i == 3) ? 10'h3FF : 10'h301 + 10'(i);
      checks++; if (fq_valid !== 1'b1 || fq_ii !== exp_ii) begin errors++; $display("[TB] FAIL fpp_order_%0d: got v=%0h ii=%0h expected v=1 ii=%0h", i, fq_valid, fq_ii, exp_ii); end
      fq_pop = 1;
      cycle();
      set_idle();
    end
    checks++; if (fq_valid !== 1'b0) begin errors++; $display("[TB] FAIL fpp_drained: got %0h expected 0", fq_valid); end
    // Clear has priority over a same-cycle push and pop on a full FIFO.
    for (int i = 0; i < 4; i++) begin
      set_fault(10'h0F0 + 10'(i));
      cycle();
    end
    set_fault(10'h0FF);
    fq_pop = 1;
    fq_clr = 1;
    cycle();
    set_idle();
    checks++; if (fq_valid !== 1'b0 || fq_drops !== 8'd0 || fq_ovf !== 1'b0) begin errors++; $display("[TB] FAIL clr_priority: got v=%0h drops=%0d ovf=%0h expected 0/0/0", fq_valid, fq_drops, fq_ovf); end
  endtask

  task automatic test_stall();
    set_idle();
    in_en = 1; in_ok = 1; in_ii = 10'h033;
    cycle();
    for (int i = 0; i < 2; i++) begin
      set_fault(10'h1C0 + 10'(i));
      stall = 1;
      cycle();
      checks++; if (out_en !== 1'b1 || out_fault !== 1'b0 || out_ii !== 10'h033) begin errors++; $display("[TB] FAIL stall_hold_%0d: got en=%0h fault=%0h ii=%0h expected 1/0/33", i, out_en, out_fault, out_ii); end
      checks++; if (fq_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_no_push_%0d: got %0h expected 0", i, fq_valid); end
    end
    flush = 1;
    cycle();
    set_idle();
    checks++; if (out_en !== 1'b0 || out_ii !== 10'h033) begin errors++; $display("[TB] FAIL stall_flush: got en=%0h ii=%0h expected 0/33", out_en, out_ii); end
  endtask

  task automatic test_flush();
    set_fault(10'h2AA);
    flush = 1;
    cycle();
    set_idle();
    checks++; if (out_en !== 1'b0 || out_fault !== 1'b0) begin errors++; $display("[TB] FAIL flush_out: got en=%0h fault=%0h expected 0/0", out_en, out_fault); end
    checks++; if (fq_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_push: got %0h expected 0", fq_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      set_fault(10'h150 + 10'(i));
      cycle();
    end
    set_fault(10'h15F);
    checks++; if (fq_valid !== 1'b1) begin errors++; $display("[TB] FAIL rmid_queued: got %0h expected 1", fq_valid); end
    rst = 1;
    cycle();
    set_idle();
    checks++; if (fq_valid !== 1'b0 || out_en !== 1'b0 || out_ii !== 10'h0) begin errors++; $display("[TB] FAIL rmid_cleared: got v=%0h en=%0h ii=%0h expected 0/0/0", fq_valid, out_en, out_ii); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_idle();
      rst    = ($urandom_range(0, 63) == 0);
      fq_clr = ($urandom_range(0, 39) == 0);
      stall  = ($urandom_range(0, 4) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      in_en  = ($urandom_range(0, 3) != 0);
      in_ok  = $urandom_range(0, 1);
      fq_pop = ($urandom_range(0, 2) == 0);
      in_ii  = 10'($urandom);
      in_ptr = {$urandom, $urandom};
      cycle();
      checks++; if (out_en !== m_out_en || out_fault !== m_out_fault || out_ii !== m_out_ii) begin errors++; $display("[TB] FAIL rnd_out_%0d: got %0h/%0h/%0h expected %0h/%0h/%0h", n, out_en, out_fault, out_ii, m_out_en, m_out_fault, m_out_ii); end
      checks++; if (fq_valid !== (mq.size() > 0)) begin errors++; $display("[TB] FAIL rnd_valid_%0d: got %0h expected %0h", n, fq_valid, mq.size() > 0); end
      checks++; if (fq_ovf !== m_ovf || fq_drops !== 8'(m_drops)) begin errors++; $display("[TB] FAIL rnd_ovf_%0d: got %0h/%0d expected %0h/%0d", n, fq_ovf, fq_drops, m_ovf, m_drops); end
      if (mq.size() > 0) begin
        checks++; if ({fq_ii, fq_exp, fq_addr} !== mq[0]) begin errors++; $display("[TB] FAIL rnd_head_%0d: got %0h expected %0h", n, {fq_ii, fq_exp, fq_addr}, mq[0]); end
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    #1;
    test_reset();
    test_pass();
    test_fault_record();
    test_overflow();
    test_full_push_pop();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
